// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register file reads, forwards MEM/WB results,
// stalls on EX producers and holds resolved operands in the ID/EX register.
module operand_fetch_stage #(
   parameter int DATA_W = 32,
   parameter int AW     = 4,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [AW-1:0]     in_ra1,
   input  logic [AW-1:0]     in_ra2,
   input  logic [AW-1:0]     in_dst,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [AW-1:0]     rf_ra1,
   output logic [AW-1:0]     rf_ra2,
   output logic [DATA_W-1:0] rf_r15,
   input  logic [DATA_W-1:0] rf_rd1,
   input  logic [DATA_W-1:0] rf_rd2,
   input  logic              ex_we,
   input  logic [AW-1:0]     ex_wa,
   input  logic              mem_we,
   input  logic [AW-1:0]     mem_wa,
   input  logic [DATA_W-1:0] mem_wd,
   input  logic              wb_we,
   input  logic [AW-1:0]     wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [AW-1:0]     out_dst,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_pc
);

   localparam logic [AW-1:0] PC_REG = AW'(15);

   logic [DATA_W-1:0] pc_plus8;
   logic [DATA_W-1:0] op1_res;
   logic [DATA_W-1:0] op2_res;
   logic              hazard;
   logic              accept;
   logic              load_en;

   // Reading r15 returns PC+8; writes to r15 redirect the PC and are never forwarded.
   function automatic logic [DATA_W-1:0] resolve(
      input logic [AW-1:0]     ra,
      input logic [DATA_W-1:0] rd,
      input logic [DATA_W-1:0] pc8
   );
      if (ra == PC_REG)
         return pc8;
      else if (mem_we && mem_wa != PC_REG && mem_wa == ra)
         return mem_wd;
      else if (wb_we && wb_wa != PC_REG && wb_wa == ra)
         return wb_wd;
      else
         return rd;
   endfunction

   assign pc_plus8 = in_pc + DATA_W'(8);
   assign rf_ra1   = in_ra1;
   assign rf_ra2   = in_ra2;
   assign rf_r15   = pc_plus8;

   assign op1_res = resolve(in_ra1, rf_rd1, pc_plus8);
   assign op2_res = resolve(in_ra2, rf_rd2, pc_plus8);

   // EX results are not yet available to forward, so a match there must wait a cycle.
   assign hazard   = in_valid && ex_we && (ex_wa != PC_REG) &&
                     ((ex_wa == in_ra1) || (ex_wa == in_ra2));
   assign load_en  = !out_valid || out_ready;
   assign in_ready = load_en && !hazard;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_op1   <= '0;
         out_op2   <= '0;
         out_dst   <= '0;
         out_ctrl  <= '0;
         out_pc    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load_en) begin
         out_valid <= accept;
         if (accept) begin
            out_op1  <= op1_res;
            out_op2  <= op2_res;
            out_dst  <= in_dst;
            out_ctrl <= in_ctrl;
            out_pc   <= in_pc;
         end
      end
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Register-read/operand stage between decode and execute.
- Drives the register file read addresses and the r15 value (PC+8), and applies MEM/WB forwarding to the returned operands.
- Stalls on producers still in EX, then latches the operands into an ID/EX pipeline register with a valid/ready handshake and flush.
- Execute consumes out_* directly.

Parameters:
DATA_W, 32, operand/PC width
AW, 4, register address width (register 15 = PC)
CTRL_W, 16, width of opaque decoded control bundle passed through

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts instruction this cycle
in_pc  in  DATA_W  instruction address
in_ra1, in_ra2  in  AW  source register addresses
in_dst  in  AW  destination register address
in_ctrl  in  CTRL_W  decoded control bundle
rf_ra1, rf_ra2  out  AW  register file read addresses
rf_r15  out  DATA_W  PC+8 supplied to register file
rf_rd1, rf_rd2  in  DATA_W  register file read data (combinational)
ex_we  in  1  instruction in EX will write a register
ex_wa  in  AW  its destination
mem_we, mem_wa, mem_wd  in  1/AW/DATA_W  MEM-stage result forward
wb_we, wb_wa, wb_wd  in  1/AW/DATA_W  WB-stage write (same as regfile write port)
flush  in  1  kill contents of the stage
out_valid  out  1  pipeline register holds a valid instruction
out_ready  in  1  execute accepts the held instruction
out_op1, out_op2  out  DATA_W  resolved operands
out_dst  out  AW  destination
out_ctrl  out  CTRL_W  control bundle
out_pc  out  DATA_W  instruction address

Behaviour:
Register read and operand forwarding (combinational):
- rf_ra1 = in_ra1; rf_ra2 = in_ra2.
- rf_r15 = in_pc + 8, modulo 2^DATA_W.
- Operand n resolution, highest priority first:
  - ra==15: PC+8.
  - mem_we && mem_wa==ra: mem_wd.
  - wb_we && wb_wa==ra: wb_wd.
  - otherwise rf_rdn.
- Writes with wa==15 never match; they are PC writes, not forwardable.

Hazard and handshake:
- hazard = in_valid && ex_we && ex_wa!=15 && (ex_wa==in_ra1 || ex_wa==in_ra2).
- Source address 15 never causes a stall.
- in_ready = (!out_valid || out_ready) && !hazard. It does not depend on flush.
- Accept = in_valid && in_ready.

Sequential, on posedge clk:
- flush=1: out_valid<=0. Payload may update or hold (don't-care). An instruction offered the same cycle is dropped and counts as consumed.
- else if (!out_valid || out_ready): out_valid<=Accept. On Accept, latch resolved operands, in_dst, in_ctrl, in_pc.
- else (out_valid && !out_ready): hold all outputs unchanged. Operands are not re-forwarded; the hazard rule guarantees no older producer can still be pending.

Reset and latency:
- rst_n=0, asynchronously: out_valid, out_op1, out_op2, out_dst, out_ctrl, out_pc all 0.
- Reset mid-handshake discards the held instruction.
- Latency: 1 cycle from accept to out_valid. Throughput: 1/cycle when out_ready=1 and no hazard.

Test Plan:
1. Reset with rst_n=0 asynchronously mid-cycle, out_valid previously 1 -> all out_* 0 immediately; in_ready=1 after release.
2. in_pc=0x100, in_ra1=15, in_ra2=3, rf_rd2=0x55, no forwards -> rf_r15=0x108; next cycle out_op1=0x108, out_op2=0x55, out_valid=1.
3. in_ra1=in_ra2=5; mem_we=1, mem_wa=5, mem_wd=0xAA; wb_we=1, wb_wa=5, wb_wd=0xBB; rf_rd=0x11 -> out_op1=out_op2=0xAA. Repeat with mem_we=0 -> 0xBB. Repeat with mem_wa=15, in_ra=15 -> PC+8.
4. ex_we=1, ex_wa=2, in_ra2=2 for 1 cycle -> in_ready=0, out_valid=0 next cycle. Next cycle ex_we=0, mem_wa=2, mem_wd=0x7 -> accepted, out_op2=0x7.
5. out_valid=1, out_ready=0 for 3 cycles while wb writes the source register -> outputs held bit-exact, in_ready=0. out_ready=1 -> next instruction loads.
6. flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the input is not captured. flush=1 with out_ready=0 -> out_valid=0 regardless.
